reg_serial_tx: RTL and testbench

REG_SERIAL_TX -- requirements
Module: reg_serial_tx

---
 rtl/reg_serial_tx.sv | 171 +++++++++++++++++
 tb/tb_reg_serial_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_serial_tx.sv
// Word-wide UART-style transmitter: sends a 16-bit word as two 8N1 frames, low byte first.
// Define REG_SERIAL_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
module reg_serial_tx #(
  parameter int BAUD_DIV   = 434,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic [15:0] Areg,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bit_idx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);

`ifdef REG_SERIAL_TX_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic           byte_q, byte_d;
  logic [15:0]    shift_q, shift_d;
  logic           done_q, done_d;
`ifdef REG_SERIAL_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic baud_tick;
  assign baud_tick = (baud_q == '0);

  // State register; reset wins over any start request seen on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= 1'b0;
      shift_q  <= '0;
      done_q   <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
`ifdef REG_SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = Areg;
          byte_d  = 1'b0;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
`ifdef REG_SERIAL_TX_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          baud_d = BAUD_RELOAD;
          // After the low byte has shifted out, the high byte sits in [7:0].
`ifdef REG_SERIAL_TX_PARITY_EN
          if (bit_q != 4'd8) begin
            shift_d  = {1'b0, shift_q[15:1]};
            parity_d = parity_q ^ shift_q[0];
          end
`else
          shift_d = {1'b0, shift_q[15:1]};
`endif
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          baud_d = BAUD_RELOAD;
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = ST_START;
          end else begin
            byte_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tx      = IDLE_LEVEL;
    busy    = (state_q != ST_IDLE);
    done    = done_q;
    bit_idx = 4'd15;

    case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA: begin
        bit_idx = bit_q;
`ifdef REG_SERIAL_TX_PARITY_EN
        tx = (bit_q == 4'd8) ? parity_q : shift_q[0];
`else
        tx = shift_q[0];
`endif
      end
      ST_STOP: tx = 1'b1;
      default: tx = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Directed bench for reg_serial_tx at BAUD_DIV=4; frame length follows REG_SERIAL_TX_PARITY_EN.
module tb_reg_serial_tx;

  localparam int B = 4;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = 2 * FB * B;

  logic        clk = 1'b0;
  logic        key0 = 1'b0;
  logic        start = 1'b0;
  logic [15:0] areg = 16'h0000;
  logic        tx;
  logic        busy;
  logic        done;
  logic [3:0]  bit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_serial_tx #(.BAUD_DIV(B), .IDLE_LEVEL(1'b1)) dut (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .Areg     (areg),
    .start    (start),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame-bit k (0..2*FB-1) of word w.
  function automatic logic exp_tx(input logic [15:0] w, input int k);
    logic [7:0] by;
    int j;
    by = (k / FB == 0) ? w[7:0] : w[15:8];
    j  = k % FB;
    if (j == 0) return 1'b0;
    if (j <= 8) return by[j-1];
    if (j == 9 && FB == 11) return ^by;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_idx(input int k);
    int j;
    j = k % FB;
    if (j == 0) return 4'd15;
    if (j <= 8) return 4'(j - 1);
    if (j == 9 && FB == 11) return 4'd8;
    return 4'd15;
  endfunction

  // Entered in cycle 1 (one cycle after the accepting edge); leaves in the done cycle,
  // or in the first cycle after reset when abort_at is non-zero.
  task automatic run_word(input logic [15:0] w, input int repulse_at, input int abort_at,
                          input logic [15:0] other);
    int k;
    for (int c = 1; c <= L; c++) begin
      k = (c - 1) / B;
      chk($sformatf("tx w=%0h c=%0d", w, c), {15'd0, tx}, {15'd0, exp_tx(w, k)});
      chk($sformatf("bit_idx w=%0h c=%0d", w, c), {12'd0, bit_idx}, {12'd0, exp_idx(k)});
      chk($sformatf("busy w=%0h c=%0d", w, c), {15'd0, busy}, 16'd1);
      chk($sformatf("done w=%0h c=%0d", w, c), {15'd0, done}, 16'd0);
      if (repulse_at > 0 && c == repulse_at) begin
        start = 1'b1;
        areg  = other;
      end else if (repulse_at > 0 && c == repulse_at + 1) begin
        start = 1'b0;
      end
      if (c == abort_at) begin
        key0 = 1'b0;
        tick();
        chk("abort tx", {15'd0, tx}, 16'd1);
        chk("abort busy", {15'd0, busy}, 16'd0);
        chk("abort bit_idx", {12'd0, bit_idx}, 16'd15);
        chk("abort done", {15'd0, done}, 16'd0);
        key0 = 1'b1;
        return;
      end
      tick();
    end
    chk($sformatf("done pulse w=%0h", w), {15'd0, done}, 16'd1);
    chk($sformatf("busy at done w=%0h", w), {15'd0, busy}, 16'd0);
    chk($sformatf("tx at done w=%0h", w), {15'd0, tx}, 16'd1);
    chk($sformatf("bit_idx at done w=%0h", w), {12'd0, bit_idx}, 16'd15);
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s busy %0d", tag, i), {15'd0, busy}, 16'd0);
      chk($sformatf("%s done %0d", tag, i), {15'd0, done}, 16'd0);
      chk($sformatf("%s tx %0d", tag, i), {15'd0, tx}, 16'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset tx", {15'd0, tx}, 16'd1);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset done", {15'd0, done}, 16'd0);
    chk("reset bit_idx", {12'd0, bit_idx}, 16'd15);
    key0 = 1'b1;
    check_idle("post-reset", 2);

    // A53C, single-cycle start: frame bits 0001111001 / 0101001011, done at cycle 20*B+1
    areg = 16'hA53C; start = 1'b1;
    tick();
    start = 1'b0;
    run_word(16'hA53C, 0, 0, 16'h0000);
    check_idle("after A53C", 3);

    // 00FF with an ignored re-pulse of 1234 at cycle 10; exactly one done
    areg = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    run_word(16'h00FF, 10, 0, 16'h1234);
    check_idle("after 00FF", 5);

    // Reset at cycle 30 aborts, then a fresh word goes out complete
    areg = 16'h5A96; start = 1'b1;
    tick();
    start = 1'b0;
    run_word(16'h5A96, 0, 30, 16'h0000);
    check_idle("after abort", 4);
    areg = 16'hC3E1; start = 1'b1;
    tick();
    start = 1'b0;
    run_word(16'hC3E1, 0, 0, 16'h0000);
    check_idle("after C3E1", 2);

    // start held high: second word starts straight out of the done cycle
    areg = 16'h0001; start = 1'b1;
    tick();
    run_word(16'h0001, 0, 0, 16'h0000);
    tick();
    run_word(16'h0001, L - 1, 0, 16'h0001);
    check_idle("after b2b", 3);

    // 0107: both bytes have odd weight, so each parity bit is 1 when enabled
    areg = 16'h0107; start = 1'b1;
    tick();
    start = 1'b0;
    run_word(16'h0107, 0, 0, 16'h0000);
    check_idle("after 0107", 2);

    // Reset held for 5 cycles with start asserted: nothing starts
    key0 = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst+start tx %0d", i), {15'd0, tx}, 16'd1);
      chk($sformatf("rst+start busy %0d", i), {15'd0, busy}, 16'd0);
    end
    key0 = 1'b1; start = 1'b0;
    check_idle("after rst+start", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
